// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, latency defaults and helpers shared by the multiply/divide unit
package mdu_pkg;
  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } op_t;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  function automatic logic is_mdu_calc(op_t op);
    return op inside {MULT, MULTU, DIV, DIVU};
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage request bus into the multiply/divide unit and its results
interface mdu_if;
  import mdu_pkg::*;
  op_t op;
  logic start;
  logic [31:0] A;
  logic [31:0] B;
  logic busy;
  logic stall_req;
  logic [31:0] rd_out;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master(output op, start, A, B, input busy, stall_req, rd_out, HI, LO);
  modport slave(input op, start, A, B, output busy, stall_req, rd_out, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and divide producing the pending HI/LO pair
module mdu_arith
  import mdu_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi_tmp,
  output logic [31:0] lo_tmp,
  output logic        div_by_zero
);
  logic [63:0] sprod, uprod;
  logic [31:0] a_mag, b_mag, q, r;
  logic sdiv;
  always_comb begin
    sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod = {32'b0, A} * {32'b0, B};
    sdiv = op == DIV;
    // signed divide on magnitudes keeps 0x80000000 / -1 well defined
    a_mag = sdiv && A[31] ? -A : A;
    b_mag = sdiv && B[31] ? -B : B;
    q = b_mag == '0 ? '0 : a_mag / b_mag;
    r = b_mag == '0 ? '0 : a_mag % b_mag;
    {hi_tmp, lo_tmp} = op == MULT ? sprod : op == MULTU ? uprod :
      {sdiv && A[31] ? -r : r, sdiv && (A[31] ^ B[31]) ? -q : q};
    div_by_zero = (op inside {DIV, DIVU}) && B == '0;
  end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: fixed-latency multiply/divide unit owning HI/LO, with stall request to hazard unit
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] hi_q, lo_q, hi_tmp, lo_tmp;
  logic skip_q, div_by_zero, idle, accept, done;
  mdu_arith u_arith (
    .op(bus.op),
    .A(bus.A),
    .B(bus.B),
    .hi_tmp(hi_tmp),
    .lo_tmp(lo_tmp),
    .div_by_zero(div_by_zero)
  );
  assign idle = state == IDLE;
  assign accept = bus.start && idle && is_mdu_calc(bus.op);
  assign done = state == BUSY && cnt == 4'd1;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb state_n = accept ? BUSY : done ? IDLE : state;
  always_comb begin
    bus.busy = state == BUSY;
    bus.stall_req = bus.busy || (bus.start && is_mdu_calc(bus.op));
    bus.rd_out = bus.op == MFHI ? bus.HI : bus.op == MFLO ? bus.LO : '0;
  end
  // result is captured at accept and held until the latency counter expires
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      hi_q <= '0;
      lo_q <= '0;
      skip_q <= 1'b0;
      bus.HI <= '0;
      bus.LO <= '0;
    end else begin
      if (accept) begin
        cnt <= bus.op inside {MULT, MULTU} ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
        hi_q <= hi_tmp;
        lo_q <= lo_tmp;
        skip_q <= div_by_zero;
      end else if (!idle) cnt <= cnt - 4'd1;
      if (done && !skip_q) begin
        bus.HI <= hi_q;
        bus.LO <= lo_q;
      end
      if (bus.start && idle && bus.op == MTHI) bus.HI <= bus.A;
      if (bus.start && idle && bus.op == MTLO) bus.LO <= bus.A;
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table, directed and random checks of mdu_unit against an arithmetic reference model
module tb_mdu_unit;
  import mdu_pkg::*;
  localparam int LM = 5;
  localparam int LD = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mdu_if bus ();
  mdu_unit #(.MUL_CYCLES(LM), .DIV_CYCLES(LD)) dut (.clk(clk), .reset(reset), .bus(bus));
  int nvec = 0, nmis = 0, prot = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic p_skip = 1'b0;
  int m_rem = 0;
  typedef struct {
    op_t o;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t tv[8];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic ref_op(op_t o, logic [31:0] a, logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    z = 1'b0;
    h = '0;
    l = '0;
    if (o == MULT || o == MULTU) begin
      p = 64'(o == MULT ? sa * sb : ua * ub);
      h = p[63:32];
      l = p[31:0];
    end else begin
      z = b == '0;
      if (!z) begin
        q = o == DIV ? sa / sb : ua / ub;
        r = o == DIV ? sa % sb : ua % ub;
        l = 32'(q);
        h = 32'(r);
      end
    end
  endtask

  task automatic cycle(op_t o, logic s, logic [31:0] a, logic [31:0] b);
    logic calc;
    calc = o == MULT || o == MULTU || o == DIV || o == DIVU;
    bus.op = o;
    bus.start = s;
    bus.A = a;
    bus.B = b;
    #1;
    chk("busy", 32'(bus.busy), 32'(m_rem > 0));
    chk("stall_req", 32'(bus.stall_req), 32'((m_rem > 0) || (s && calc)));
    chk("rd_out", bus.rd_out, o == MFHI ? m_hi : o == MFLO ? m_lo : 32'h0);
    chk("HI", bus.HI, m_hi);
    chk("LO", bus.LO, m_lo);
    if (s && m_rem > 0 && reset) prot++;
    @(posedge clk);
    if (!reset) begin
      m_hi = '0;
      m_lo = '0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !p_skip) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s) begin
      if (calc) begin
        ref_op(o, a, b, p_hi, p_lo, p_skip);
        m_rem = (o == MULT || o == MULTU) ? LM : LD;
      end else if (o == MTHI) m_hi = a;
      else if (o == MTLO) m_lo = a;
    end
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (bus.busy && n < 20) begin
      cycle(NONE, 1'b0, '0, '0);
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tv[0] = '{MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tv[1] = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tv[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    tv[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[5] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tv[6] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    tv[7] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    bus.op = NONE;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(NONE, 1'b0, '0, '0);
    reset = 1'b1;
    chk("reset HI", bus.HI, 32'h0);
    chk("reset LO", bus.LO, 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);

    foreach (tv[i]) begin
      cycle(tv[i].o, 1'b1, tv[i].a, tv[i].b);
      drain(n);
      chk("latency", 32'(n), 32'((tv[i].o == MULT || tv[i].o == MULTU) ? LM : LD));
      chk("table HI", bus.HI, tv[i].eh);
      chk("table LO", bus.LO, tv[i].el);
    end

    cycle(MTHI, 1'b1, 32'h11, '0);
    cycle(MTLO, 1'b1, 32'h22, '0);
    cycle(DIV, 1'b1, 32'h5, 32'h0);
    drain(n);
    chk("div0 latency", 32'(n), 32'(LD));
    chk("div0 HI", bus.HI, 32'h11);
    chk("div0 LO", bus.LO, 32'h22);

    cycle(MULT, 1'b1, 32'h3, 32'h4);
    chk("mult stall", 32'(bus.stall_req), 32'h1);
    cycle(MTLO, 1'b1, 32'h55, '0);
    cycle(MFHI, 1'b1, '0, '0);
    drain(n);
    chk("busy-mtlo LO", bus.LO, 32'hC);
    chk("busy-mtlo HI", bus.HI, 32'h0);

    cycle(MTHI, 1'b1, 32'hDEADBEEF, '0);
    chk("mthi HI", bus.HI, 32'hDEADBEEF);
    cycle(MFHI, 1'b1, '0, '0);
    bus.op = MFHI;
    #1;
    chk("mfhi rd_out", bus.rd_out, 32'hDEADBEEF);
    chk("mfhi stall", 32'(bus.stall_req), 32'h0);

    cycle(MTLO, 1'b1, 32'h1234, '0);
    cycle(DIV, 1'b1, 32'd100, 32'd7);
    repeat (3) cycle(NONE, 1'b0, '0, '0);
    reset = 1'b0;
    repeat (2) cycle(NONE, 1'b0, '0, '0);
    reset = 1'b1;
    chk("midrst busy", 32'(bus.busy), 32'h0);
    chk("midrst HI", bus.HI, 32'h0);
    chk("midrst LO", bus.LO, 32'h0);
    repeat (12) cycle(NONE, 1'b0, '0, '0);

    for (int k = 0; k < 600; k++) begin
      reset = $urandom_range(0, 60) != 0;
      cycle(op_t'($urandom_range(0, 8)), $urandom_range(0, 3) != 0, pick(), pick());
    end
    reset = 1'b1;
    repeat (12) cycle(NONE, 1'b0, '0, '0);

    $display("protocol: %0d starts presented while busy were ignored", prot);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
